// File: rtl/serial_cmp_ctrl.sv
// Serial magnitude comparator: walks two WIDTH-bit operands MSB to LSB through
// one shared 1-bit compare cell, two passes (less, then greater) per bit.

module serial_cmp_cell (
    input  logic abit,
    input  logic bbit,
    input  logic chave,
    output logic hit
);
    // chave=0 asks "a<b" on this bit, chave=1 asks "a>b".
    assign hit = chave ? (abit & ~bbit) : (~abit & bbit);
endmodule

module serial_cmp_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             gt,
    output logic             eq,
    output logic             chave
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CMP_LT = 2'd1,
        CMP_GT = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [IW-1:0]    idx;
    logic             cell_sel;
    logic             hit;

    assign cell_sel = (state == CMP_GT);

    serial_cmp_cell u_cell (
        .abit  (opa[idx]),
        .bbit  (opb[idx]),
        .chave (cell_sel),
        .hit   (hit)
    );

    // Status outputs decode the state register only, so no input reaches them
    // combinationally.
    assign busy  = (state == CMP_LT) || (state == CMP_GT);
    assign done  = (state == DONE);
    assign chave = cell_sel;

    always_comb begin
        // NOTE: default first so every path assigns state_nxt; no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CMP_LT;
            CMP_LT:  state_nxt = hit ? DONE : CMP_GT;
            CMP_GT:  state_nxt = (hit || (idx == '0)) ? DONE : CMP_LT;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand, index and result registers. A mid-scan reset clears the flags,
    // so an aborted compare never leaves a stale result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opa <= '0;
            opb <= '0;
            idx <= '0;
            lt  <= 1'b0;
            gt  <= 1'b0;
            eq  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        opa <= a;
                        opb <= b;
                        idx <= IW'(WIDTH - 1);
                        lt  <= 1'b0;
                        gt  <= 1'b0;
                        eq  <= 1'b0;
                    end
                end
                CMP_LT: begin
                    if (hit) lt <= 1'b1;
                end
                CMP_GT: begin
                    if (hit) begin
                        gt <= 1'b1;
                    end else if (idx == '0) begin
                        eq <= 1'b1;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Self-checking bench for serial_cmp_ctrl: directed cases plus random operands
// checked cycle by cycle against a result/latency model.

module tb_serial_cmp_ctrl;
    localparam int WIDTH = 8;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a     = '0;
    logic [WIDTH-1:0] b     = '0;
    logic             busy, done, lt, gt, eq, chave;

    int n_checks = 0;
    int n_fail   = 0;

    serial_cmp_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .lt    (lt),
        .gt    (gt),
        .eq    (eq),
        .chave (chave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Cell evaluations needed: found from the most significant differing bit.
    function automatic int evals(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        if (x == y) return 2 * WIDTH;
        for (int i = WIDTH - 1; i >= 0; i--)
            if (x[i] != y[i]) return 2 * (WIDTH - 1 - i) + ((x < y) ? 1 : 2);
        return 0;
    endfunction

    // Expected {lt,gt,eq}.
    function automatic logic [2:0] exp_flags(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        if (x < y) return 3'b100;
        if (x > y) return 3'b010;
        return 3'b001;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One compare. inject_at>0 pulses a stray start after that edge; reset_at>0
    // pulses rst_n after that edge and expects the compare to be aborted.
    task automatic run_cmp(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                           input int inject_at, input int reset_at);
        int n;
        n = evals(xa, xb);
        a = xa;
        b = xb;
        start = 1'b1;
        if (done) begin
            tick();
            check("start_in_done_ignored", {30'd0, busy, done}, 32'd0);
        end
        tick();
        start = 1'b0;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        for (int k = 1; k <= n; k++) begin
            check("busy_scan", busy, 1);
            check("done_early", done, 0);
            check("chave_seq", chave, (k - 1) % 2);
            check("flags_cleared", {lt, gt, eq}, 0);
            if (k == inject_at) begin
                start = 1'b1;
                a = '0;
                b = '1;
            end
            if (k == reset_at) rst_n = 1'b0;
            tick();
            start = 1'b0;
            if (k == reset_at) begin
                rst_n = 1'b1;
                check("reset_abort", {busy, done, lt, gt, eq, chave}, 0);
                return;
            end
        end
        check("done_pulse", done, 1);
        check("busy_in_done", busy, 0);
        check("chave_in_done", chave, 0);
        check("result", {lt, gt, eq}, exp_flags(xa, xb));
    endtask

    task automatic idle_cycles(input int c, input logic [2:0] flags);
        for (int i = 0; i < c; i++) begin
            tick();
            check("idle_done", done, 0);
            check("idle_busy", busy, 0);
            check("idle_chave", chave, 0);
            check("flags_hold", {lt, gt, eq}, flags);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        rst_n = 1'b0;
        tick();
        tick();
        check("reset_outputs", {busy, done, lt, gt, eq, chave}, 0);
        rst_n = 1'b1;
        idle_cycles(1, 3'b000);

        run_cmp(8'h35, 8'h80, 0, 0);
        idle_cycles(2, 3'b100);
        run_cmp(8'h80, 8'h35, 0, 0);
        idle_cycles(1, 3'b010);
        run_cmp(8'hA5, 8'hA5, 0, 0);
        idle_cycles(1, 3'b001);
        run_cmp(8'h12, 8'h13, 0, 0);
        run_cmp(8'h13, 8'h12, 0, 0);
        idle_cycles(1, 3'b010);
        run_cmp(8'hA5, 8'hA5, 3, 0);
        idle_cycles(3, 3'b001);
        run_cmp(8'hA5, 8'hA5, 0, 5);
        idle_cycles(1, 3'b000);
        run_cmp(8'h01, 8'h00, 0, 0);
        idle_cycles(1, 3'b010);

        for (int t = 0; t < 60; t++) begin
            ra = WIDTH'($urandom);
            case ($urandom_range(3, 0))
                0:       rb = ra;
                1:       rb = ra ^ (WIDTH'(1) << $urandom_range(WIDTH - 1, 0));
                default: rb = WIDTH'($urandom);
            endcase
            run_cmp(ra, rb, 0, 0);
            if ($urandom_range(1, 0) == 1)
                idle_cycles($urandom_range(3, 1), exp_flags(ra, rb));
        end
        idle_cycles(1, exp_flags(ra, rb));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
